// File: rtl/lcomp_threshold_slew.sv
// Threshold slew limiter feeding lcompressor: ramps the symmetric threshold toward a
// requested target at SLEW_STEP per sample. Optional macro LCOMP_THR_ZC_EN gates steps to zero crossings.
module lcomp_threshold_slew #(
    parameter int unsigned        W_TOTAL        = 16,
    parameter int unsigned        SLEW_STEP      = 64,
    parameter logic [W_TOTAL-1:0] INIT_THRESHOLD = {1'b0, {(W_TOTAL-1){1'b1}}}
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_ce,
    input  logic signed [W_TOTAL-1:0] i_data,
    input  logic signed [W_TOTAL-1:0] i_thr_req,
    input  logic                      i_thr_load,
    output logic signed [W_TOTAL-1:0] o_data,
    output logic signed [W_TOTAL-1:0] o_threshold_pos,
    output logic signed [W_TOTAL-1:0] o_threshold_neg,
    output logic                      o_ce,
    output logic                      o_busy
);

    localparam int unsigned        WD       = W_TOTAL + 1;
    localparam int unsigned        MSB      = W_TOTAL - 1;
    localparam logic [WD-1:0]      STEP_W   = WD'(SLEW_STEP);
    localparam logic [W_TOTAL-1:0] INIT_NEG = {W_TOTAL{1'b0}} - INIT_THRESHOLD;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [W_TOTAL-1:0] cur_q, cur_d;
    logic [W_TOTAL-1:0] target_q, target_d;
    logic [W_TOTAL-1:0] thr_neg_q, thr_neg_d;
    logic [W_TOTAL-1:0] data_q, data_d;
    logic               ce_q, ce_d;
    logic               busy_q, busy_d;

    logic [WD-1:0]      cur_ext, tgt_ext, mag, cur_step_w;
    logic               up, near, step_en;

    // Distance to target in W_TOTAL+1 bits so neither the difference nor the step wraps.
    always_comb begin
        cur_ext    = {1'b0, cur_q};
        tgt_ext    = {1'b0, target_q};
        up         = (tgt_ext >= cur_ext);
        mag        = up ? (tgt_ext - cur_ext) : (cur_ext - tgt_ext);
        near       = (mag <= STEP_W);
        cur_step_w = up ? (cur_ext + STEP_W) : (cur_ext - STEP_W);
    end

`ifdef LCOMP_THR_ZC_EN
    logic sign_q, sign_d;

    // Steps are only allowed where the audio crosses (or sits at) zero.
    always_comb begin
        sign_d = sign_q;
        if (i_ce) begin
            sign_d = i_data[MSB];
        end
        step_en = i_ce && ((i_data[MSB] != sign_q) || (i_data == '0));
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end
`else
    assign step_en = i_ce;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (target_q != cur_q) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (target_q == cur_q) begin
                    state_d = ST_IDLE;
                end else if (step_en && near) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic; a same-cycle load only affects target_d, so the step uses the old target.
    always_comb begin
        cur_d    = cur_q;
        target_d = target_q;
        data_d   = data_q;
        ce_d     = i_ce;
        if ((state_q == ST_RAMP) && step_en && (target_q != cur_q)) begin
            cur_d = near ? target_q : cur_step_w[W_TOTAL-1:0];
        end
        if (i_thr_load) begin
            target_d = i_thr_req[MSB] ? '0 : i_thr_req;
        end
        if (i_ce) begin
            data_d = i_data;
        end
        thr_neg_d = {W_TOTAL{1'b0}} - cur_d;
        busy_d    = (state_d == ST_RAMP);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cur_q     <= INIT_THRESHOLD;
            target_q  <= INIT_THRESHOLD;
            thr_neg_q <= INIT_NEG;
            data_q    <= '0;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            target_q  <= target_d;
            thr_neg_q <= thr_neg_d;
            data_q    <= data_d;
            ce_q      <= ce_d;
            busy_q    <= busy_d;
        end
    end

    assign o_data          = data_q;
    assign o_threshold_pos = cur_q;
    assign o_threshold_neg = thr_neg_q;
    assign o_ce            = ce_q;
    assign o_busy          = busy_q;

endmodule
